// File: rtl/mlp_neuron_seq.sv
// Sequencer for a signed 4b x 4b multiply-accumulate-ReLU neuron: one pair per cycle, result at t0+len+1.
// Input stalls freeze the count; the result holds until out_ready. MLP_SEQ_SAT_EN selects saturating adds.
module mlp_neuron_seq #(
    parameter int N_MAX = 16,
    parameter int LEN_W = $clog2(N_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [15:0]      bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_i,
    input  logic [3:0]       in_w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_raw,
    output logic [15:0]      out_relu,
    output logic             ovf,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(N_MAX);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [1:0]       state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             aovf_q, aovf_d;
    logic [15:0]      raw_q, raw_d;
    logic [15:0]      relu_q, relu_d;
    logic             ovf_q, ovf_d;

    logic [LEN_W-1:0] len_c;
    logic [7:0]       prod;
    logic [15:0]      prod_ext;
    logic [15:0]      sum_wrap;
    logic [15:0]      sum;
    logic             add_ovf;

    function automatic logic [15:0] relu16(input logic [15:0] v);
        return (!v[15] && (v != 16'h0000)) ? v : 16'h0000;
    endfunction

    // Low 8 bits of the product of sign-extended operands equal the signed product.
    assign prod     = {{4{in_i[3]}}, in_i} * {{4{in_w[3]}}, in_w};
    assign prod_ext = {{8{prod[7]}}, prod};
    assign sum_wrap = acc_q + prod_ext;
    assign add_ovf  = (acc_q[15] == prod_ext[15]) && (sum_wrap[15] != acc_q[15]);

`ifdef MLP_SEQ_SAT_EN
    assign sum = add_ovf ? (acc_q[15] ? 16'h8000 : 16'h7FFF) : sum_wrap;
`else
    assign sum = sum_wrap;
`endif

    assign len_c = (len > LEN_MAX) ? LEN_MAX : len;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        aovf_d  = aovf_q;
        raw_d   = raw_q;
        relu_d  = relu_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d  = bias;
                    aovf_d = 1'b0;
                    if (len_c == '0) begin
                        state_d = S_OUT;
                        raw_d   = bias;
                        relu_d  = relu16(bias);
                        ovf_d   = 1'b0;
                    end else begin
                        cnt_d   = len_c;
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    acc_d  = sum;
                    aovf_d = aovf_q | add_ovf;
                    cnt_d  = cnt_q - LEN_ONE;
                    // Result registers are loaded on the last pair so OUT shows them immediately.
                    if (cnt_q == LEN_ONE) begin
                        state_d = S_OUT;
                        raw_d   = sum;
                        relu_d  = relu16(sum);
                        ovf_d   = aovf_q | add_ovf;
                    end
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= 16'h0000;
            cnt_q   <= '0;
            aovf_q  <= 1'b0;
            raw_q   <= 16'h0000;
            relu_q  <= 16'h0000;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            aovf_q  <= aovf_d;
            raw_q   <= raw_d;
            relu_q  <= relu_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign out_raw   = raw_q;
    assign out_relu  = relu_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mlp_neuron_seq.sv
// Directed bench for mlp_neuron_seq: stimulus pushes expected results, a monitor checks each output handshake.
module tb_mlp_neuron_seq;

    localparam int LEN_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [15:0]      bias;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_i;
    logic [3:0]       in_w;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_raw;
    logic [15:0]      out_relu;
    logic             ovf;
    logic             busy;

    mlp_neuron_seq #(.N_MAX(16), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_i      (in_i),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_raw   (out_raw),
        .out_relu  (out_relu),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] raw;
        logic [15:0] relu;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   pi[16];
    int   pw[16];
    bit   saw_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("out_raw", {16'd0, out_raw}, {16'd0, mon_e.raw});
                chk("out_relu", {16'd0, out_relu}, {16'd0, mon_e.relu});
                chk("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
            end
        end
    end

    task automatic start_op(input int l, input logic [15:0] b);
        start = 1'b1;
        len   = l[LEN_W-1:0];
        bias  = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_pair(input int i, input int w);
        int k;
        k        = 0;
        in_i     = i[3:0];
        in_w     = w[3:0];
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("pair_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Ends on the first negedge where out_valid is seen.
    task automatic run_op(input string nm, input int l, input int npairs, input logic [15:0] b,
                          input int stall, input logic [15:0] e_raw, input logic [15:0] e_relu,
                          input logic e_ovf, input int e_lat);
        int n;
        bit seen;
        n       = 0;
        seen    = 1'b0;
        saw_rdy = 1'b0;
        sb_q.push_back('{raw: e_raw, relu: e_relu, ovf: e_ovf});
        start_op(l, b);
        fork
            begin
                while (!seen && n < 300) begin
                    @(negedge clk);
                    n++;
                    if (in_ready) saw_rdy = 1'b1;
                    if (out_valid) seen = 1'b1;
                end
                if (!seen) chk({nm, "_timeout"}, {31'd0, out_valid}, 32'd1);
                else if (e_lat > 0) chk({nm, "_latency"}, n, e_lat);
            end
            begin
                for (int k = 0; k < npairs; k++) begin
                    if (k > 0 && stall > 0) begin
                        repeat (stall) @(posedge clk);
                        #1;
                    end
                    send_pair(pi[k], pw[k]);
                end
            end
        join
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        bias      = 16'h0;
        in_valid  = 1'b0;
        in_i      = 4'h0;
        in_w      = 4'h0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_raw", {16'd0, out_raw}, 32'd0);
        chk("rst_out_relu", {16'd0, out_relu}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // 6 - 4 + 49 = 51
        pi[0] = 2;  pw[0] = 3;
        pi[1] = -1; pw[1] = 4;
        pi[2] = 7;  pw[2] = 7;
        run_op("t1", 3, 3, 16'd0, 0, 16'd51, 16'd51, 1'b0, 4);
        @(posedge clk); #1;

        // 10 - 56 - 56 = -102
        pi[0] = -8; pw[0] = 7;
        pi[1] = -8; pw[1] = 7;
        run_op("t2", 2, 2, 16'd10, 0, 16'hFF9A, 16'h0000, 1'b0, 3);
        @(posedge clk); #1;

        run_op("t3", 0, 0, 16'd5, 0, 16'd5, 16'd5, 1'b0, 1);
        chk("t3_no_in_ready", {31'd0, saw_rdy}, 32'd0);
        @(posedge clk); #1;

        // Stalled inputs, held output, ignored start
        pi[0] = 2;  pw[0] = 3;
        pi[1] = -1; pw[1] = 4;
        pi[2] = 7;  pw[2] = 7;
        out_ready = 1'b0;
        run_op("t4", 3, 3, 16'd0, 2, 16'd51, 16'd51, 1'b0, -1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                start = 1'b1;
                len   = 5'd1;
                bias  = 16'd100;
            end
            if (c == 2) start = 1'b0;
            @(negedge clk);
            chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t4_hold_raw", {16'd0, out_raw}, 32'd51);
            chk("t4_hold_busy", {31'd0, busy}, 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_idle_busy", {31'd0, busy}, 32'd0);
        chk("t4_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_keep_raw", {16'd0, out_raw}, 32'd51);
        @(posedge clk); #1;
        chk("t4_start_ignored", {31'd0, busy}, 32'd0);

        // 32767 + 64 overflows
        pi[0] = -8; pw[0] = -8;
`ifdef MLP_SEQ_SAT_EN
        run_op("t5", 1, 1, 16'h7FFF, 0, 16'h7FFF, 16'h7FFF, 1'b1, 2);
`else
        run_op("t5", 1, 1, 16'h7FFF, 0, 16'h803F, 16'h0000, 1'b1, 2);
`endif
        @(posedge clk); #1;

        // len above N_MAX runs 16 pairs
        for (int k = 0; k < 16; k++) begin
            pi[k] = 1;
            pw[k] = 1;
        end
        run_op("clamp", 31, 16, 16'd0, 0, 16'd16, 16'd16, 1'b0, 17);
        @(posedge clk); #1;

        // Reset mid-operation
        start_op(4, 16'd0);
        send_pair(1, 2);
        send_pair(3, 4);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t6_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_out_raw", {16'd0, out_raw}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_still_idle", {31'd0, busy}, 32'd0);
        pi[0] = 3; pw[0] = 3;
        run_op("t6b", 1, 1, 16'd0, 0, 16'd9, 16'd9, 1'b0, 2);
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
